// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 raster constants and coordinate type
package vga_timing_pkg;
    localparam int COORD_W      = 10;
    localparam int MAX_TOTAL    = 1 << COORD_W;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef logic [COORD_W-1:0] coord_t;

    // Half-open range test lo <= v < hi, used for sync windows
    function automatic logic in_range(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v < hi);
    endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: modulo-TOTAL position counter exposing its next value
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL = H_TOTAL_DEF
) (
    input  logic   vga_clk,
    input  logic   reset_n,
    input  logic   inc,
    output coord_t count,
    output coord_t next_count,
    output logic   wrap
);
    localparam coord_t LAST = coord_t'(TOTAL - 1);

    // Reset parks at the last position so the first live edge wraps to 0
    always_ff @(posedge vga_clk) begin
        if (!reset_n) count <= LAST;
        else          count <= next_count;
    end

    // Advance on inc, wrapping to 0 after the last position
    always_comb begin
        wrap       = inc && (count == LAST);
        next_count = wrap ? '0 : count + coord_t'(inc);
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing with registered, skew-free outputs
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    output coord_t      DrawX,
    output coord_t      DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        vblank,
    output logic        frame_start,
    output logic [15:0] frame_count
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed coordinate range");
    end

    localparam coord_t H_VIS     = coord_t'(H_ACTIVE);
    localparam coord_t V_VIS     = coord_t'(V_ACTIVE);
    localparam coord_t HS_START  = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END    = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_START  = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END    = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    coord_t hc, vc, h_next, v_next;
    logic   h_wrap, v_wrap;
    logic   unused_counts;

    // The live counters only feed the output registers through next_count
    assign unused_counts = ^{hc, vc};

    vga_axis_counter #(.TOTAL(H_TOTAL)) u_h (
        .vga_clk   (vga_clk),
        .reset_n   (reset_n),
        .inc       (1'b1),
        .count     (hc),
        .next_count(h_next),
        .wrap      (h_wrap)
    );

    vga_axis_counter #(.TOTAL(V_TOTAL)) u_v (
        .vga_clk   (vga_clk),
        .reset_n   (reset_n),
        .inc       (h_wrap),
        .count     (vc),
        .next_count(v_next),
        .wrap      (v_wrap)
    );

    // Every output is decoded from the next counter state so all describe one pixel
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            DrawX       <= '0;
            DrawY       <= '0;
            blank       <= 1'b0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            vblank      <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            DrawX       <= h_next;
            DrawY       <= v_next;
            blank       <= (h_next < H_VIS) && (v_next < V_VIS);
            hs          <= !in_range(h_next, HS_START, HS_END);
            vs          <= !in_range(v_next, VS_START, VS_END);
            vblank      <= v_next >= V_VIS;
            frame_start <= v_wrap;
            frame_count <= frame_count + 16'(v_wrap);
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks on a full-size and a shrunken raster
module tb_vga_timing_gen;
    logic vga_clk = 1'b0;
    logic rst_d = 1'b0;
    logic rst_s = 1'b0;
    logic [9:0] d_x, d_y, s_x, s_y;
    logic d_b, d_h, d_v, d_vb, d_fs, s_b, s_h, s_v, s_vb, s_fs;
    logic [15:0] d_fc, s_fc;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int          n;
        logic [40:0] e;
    } vec_t;

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen dut_d (
        .vga_clk(vga_clk), .reset_n(rst_d), .DrawX(d_x), .DrawY(d_y),
        .blank(d_b), .hs(d_h), .vs(d_v), .vblank(d_vb),
        .frame_start(d_fs), .frame_count(d_fc)
    );

    // 16 x 10 raster: hs low x 10..12, vs low y 7..8, vblank y >= 6
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_s (
        .vga_clk(vga_clk), .reset_n(rst_s), .DrawX(s_x), .DrawY(s_y),
        .blank(s_b), .hs(s_h), .vs(s_v), .vblank(s_vb),
        .frame_start(s_fs), .frame_count(s_fc)
    );

    function automatic logic [40:0] pk(logic [9:0] x, logic [9:0] y, logic b, logic h,
                                       logic v, logic vb, logic fs, logic [15:0] fc);
        return {x, y, b, h, v, vb, fs, fc};
    endfunction

    function automatic vec_t mk(int n, int x, int y, logic b, logic h, logic v,
                                logic vb, logic fs, int fc);
        vec_t r;
        r.n = n;
        r.e = pk(10'(x), 10'(y), b, h, v, vb, fs, 16'(fc));
        return r;
    endfunction

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [40:0] act, input logic [40:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [40:0] s_out();
        return pk(s_x, s_y, s_b, s_h, s_v, s_vb, s_fs, s_fc);
    endfunction

    function automatic logic [40:0] d_out();
        return pk(d_x, d_y, d_b, d_h, d_v, d_vb, d_fs, d_fc);
    endfunction

    initial begin
        vec_t tbl[18];
        int n;
        int blank_fall, hs_cnt, hs_first, hs_last, mism, b_cnt, v_cnt, fs_cnt;
        logic prev_b;
        tbl[0]  = mk(0,   0,  0, 1, 1, 1, 0, 1, 1);
        tbl[1]  = mk(1,   1,  0, 1, 1, 1, 0, 0, 1);
        tbl[2]  = mk(7,   7,  0, 1, 1, 1, 0, 0, 1);
        tbl[3]  = mk(8,   8,  0, 0, 1, 1, 0, 0, 1);
        tbl[4]  = mk(10,  10, 0, 0, 0, 1, 0, 0, 1);
        tbl[5]  = mk(12,  12, 0, 0, 0, 1, 0, 0, 1);
        tbl[6]  = mk(13,  13, 0, 0, 1, 1, 0, 0, 1);
        tbl[7]  = mk(15,  15, 0, 0, 1, 1, 0, 0, 1);
        tbl[8]  = mk(16,  0,  1, 1, 1, 1, 0, 0, 1);
        tbl[9]  = mk(95,  15, 5, 0, 1, 1, 0, 0, 1);
        tbl[10] = mk(96,  0,  6, 0, 1, 1, 1, 0, 1);
        tbl[11] = mk(111, 15, 6, 0, 1, 1, 1, 0, 1);
        tbl[12] = mk(112, 0,  7, 0, 1, 0, 1, 0, 1);
        tbl[13] = mk(139, 11, 8, 0, 0, 0, 1, 0, 1);
        tbl[14] = mk(144, 0,  9, 0, 1, 1, 1, 0, 1);
        tbl[15] = mk(159, 15, 9, 0, 1, 1, 1, 0, 1);
        tbl[16] = mk(160, 0,  0, 1, 1, 1, 0, 1, 2);
        tbl[17] = mk(161, 1,  0, 1, 1, 1, 0, 0, 2);

        repeat (5) tick();
        chk("reset_full", d_out(), pk(0, 0, 0, 1, 1, 0, 0, 0));
        chk("reset_small", s_out(), pk(0, 0, 0, 1, 1, 0, 0, 0));

        rst_d = 1'b1;
        tick();
        chk("first_edge_full", d_out(), pk(0, 0, 1, 1, 1, 0, 1, 1));
        blank_fall = -1; hs_cnt = 0; hs_first = -1; hs_last = -1; prev_b = d_b;
        for (int k = 1; k <= 800; k++) begin
            tick();
            if (prev_b && !d_b && blank_fall < 0) blank_fall = int'(d_x);
            if (!d_h) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(d_x);
                hs_last = int'(d_x);
            end
            prev_b = d_b;
            if (k == 799) chk("line_end", 41'({d_x, d_y}), 41'({10'd799, 10'd0}));
        end
        chk("line_wrap", d_out(), pk(0, 1, 1, 1, 1, 0, 0, 1));
        chk("blank_fall_x", 41'(blank_fall), 41'(640));
        chk("hs_width", 41'(hs_cnt), 41'(96));
        chk("hs_first", 41'(hs_first), 41'(656));
        chk("hs_last", 41'(hs_last), 41'(751));

        rst_s = 1'b1;
        tick();
        n = 0;
        foreach (tbl[i]) begin
            while (n < tbl[i].n) begin
                tick();
                n++;
            end
            chk($sformatf("vec_n%0d", tbl[i].n), s_out(), tbl[i].e);
        end

        while (n < 320) begin
            tick();
            n++;
        end
        mism = 0; b_cnt = 0; hs_cnt = 0; v_cnt = 0; fs_cnt = 0;
        for (int k = 0; k < 160; k++) begin
            int ex, ey;
            ex = k % 16;
            ey = k / 16;
            if (s_out() !== pk(10'(ex), 10'(ey), ex < 8 && ey < 6, !(ex >= 10 && ex <= 12),
                               !(ey >= 7 && ey <= 8), ey >= 6, k == 0, 16'd3)) begin
                mism++;
                if (mism <= 3)
                    $display("FAIL sweep_cycle%0d: got %h", k, s_out());
            end
            b_cnt  += int'(s_b);
            hs_cnt += int'(!s_h);
            v_cnt  += int'(!s_v);
            fs_cnt += int'(s_fs);
            tick();
            n++;
        end
        chk("sweep_mismatches", 41'(mism), 41'(0));
        chk("visible_cycles", 41'(b_cnt), 41'(48));
        chk("hs_low_cycles", 41'(hs_cnt), 41'(30));
        chk("vs_low_cycles", 41'(v_cnt), 41'(32));
        chk("frame_pulses", 41'(fs_cnt), 41'(1));
        chk("frame3_start", s_out(), pk(0, 0, 1, 1, 1, 0, 1, 4));

        while (n < 603) begin
            tick();
            n++;
        end
        chk("pre_reset", s_out(), pk(11, 7, 0, 0, 0, 1, 0, 4));
        rst_s = 1'b0;
        tick();
        chk("mid_reset", s_out(), pk(0, 0, 0, 1, 1, 0, 0, 0));
        rst_s = 1'b1;
        tick();
        chk("restart", s_out(), pk(0, 0, 1, 1, 1, 0, 1, 1));
        tick();
        chk("restart_next", s_out(), pk(1, 0, 1, 1, 1, 0, 0, 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
